// File: rtl/cpu_wr_sync_if.sv
// rtl/cpu_wr_sync_if.sv - CPU write bus and register-bank write port bundle
interface cpu_wr_sync_if;
    logic       cpu_cs_n;
    logic       cpu_wr_n;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_ack;
    logic       my_wr;
    logic       CS_reg1;
    logic       CS_reg2;
    logic       CS_reg3;
    logic [7:0] data_in;
    logic [7:0] wr_cnt;

    modport slave (
        input  cpu_cs_n, cpu_wr_n, cpu_addr, cpu_data,
        output cpu_ack, my_wr, CS_reg1, CS_reg2, CS_reg3, data_in, wr_cnt
    );

    modport master (
        output cpu_cs_n, cpu_wr_n, cpu_addr, cpu_data,
        input  cpu_ack, my_wr, CS_reg1, CS_reg2, CS_reg3, data_in, wr_cnt
    );
endinterface

// File: rtl/cpu_wr_sync.sv
// rtl/cpu_wr_sync.sv - synchronised CPU write strobe to register-bank write port
module cpu_wr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_wr_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strb;
    logic                   strb_s;
    logic [1:0]             addr_q;
    logic [7:0]             data_q;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic [2:0]             cs_q;
    logic [2:0]             cs_d;
    logic                   my_wr_q;
    logic                   ack_q;

    assign strb = ~bus.cpu_cs_n & ~bus.cpu_wr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strb};
        end
    end

    assign strb_s = sync_q[SYNC_STAGES-1];

    // Address and data are stable by bus contract, so decoding straight off the pins is safe in QUAL.
    always_comb begin
        cs_d = 3'b000;
        case (bus.cpu_addr)
            2'b01:   cs_d = 3'b001;
            2'b10:   cs_d = 3'b010;
            2'b11:   cs_d = 3'b100;
            default: cs_d = 3'b000;
        endcase
        cnt_d = cnt_q + ((addr_q != 2'b00) ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 2'b00;
            data_q  <= 8'h00;
            cnt_q   <= 8'h00;
            cs_q    <= 3'b000;
            my_wr_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cs_q  <= 3'b000;
                    ack_q <= 1'b0;
                    if (strb_s) begin
                        state_q <= QUAL;
                    end
                end
                QUAL: begin
                    // A strobe that vanished after one synchronised sample is a glitch.
                    if (strb_s) begin
                        addr_q  <= bus.cpu_addr;
                        data_q  <= bus.cpu_data;
                        cs_q    <= cs_d;
                        my_wr_q <= 1'b1;
                        state_q <= WRITE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    my_wr_q <= 1'b0;
                    ack_q   <= 1'b1;
                    cnt_q   <= cnt_d;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!strb_s) begin
                        ack_q   <= 1'b0;
                        cs_q    <= 3'b000;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    my_wr_q <= 1'b0;
                    ack_q   <= 1'b0;
                    cs_q    <= 3'b000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.my_wr   = my_wr_q;
    assign bus.CS_reg1 = cs_q[0];
    assign bus.CS_reg2 = cs_q[1];
    assign bus.CS_reg3 = cs_q[2];
    assign bus.data_in = data_q;
    assign bus.cpu_ack = ack_q;
    assign bus.wr_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_wr_sync.sv
// tb/tb_cpu_wr_sync.sv - randomized scoreboard bench for cpu_wr_sync
module tb_cpu_wr_sync;

    localparam int SS = 2;

    typedef struct {
        logic [2:0] cs;
        logic [7:0] data;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    exp_t exp_q[$];
    int   fall_q[$];

    int         model_cnt;
    logic [7:0] model_data;

    cpu_wr_sync_if bus ();

    cpu_wr_sync #(.SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write pulse or drops its ack.
    logic       pend;
    logic [7:0] pend_cnt;
    logic [2:0] pend_cs;
    logic       ack_prev;

    always @(negedge clk) begin
        logic [2:0] cs_now;
        exp_t       e;
        int         fc;
        cs_now = {bus.CS_reg3, bus.CS_reg2, bus.CS_reg1};
        if (!rst_n) begin
            pend     = 1'b0;
            ack_prev = 1'b0;
        end else begin
            check("one_hot", ($countones(cs_now) <= 1) ? 1 : 0, 1);
            if (pend) begin
                check("my_wr_width", bus.my_wr, 0);
                check("ack_rise", bus.cpu_ack, 1);
                check("wr_cnt", bus.wr_cnt, pend_cnt);
                check("cs_hold", cs_now, pend_cs);
                pend = 1'b0;
            end
            if (bus.my_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_my_wr", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_latency", cyc, e.cyc);
                    check("cs_sel", cs_now, e.cs);
                    check("data_in", bus.data_in, e.data);
                    pend     = 1'b1;
                    pend_cnt = e.cnt;
                    pend_cs  = e.cs;
                end
            end
            if (ack_prev && !bus.cpu_ack) begin
                if (fall_q.size() == 0) begin
                    check("unexpected_ack_fall", 1, 0);
                end else begin
                    fc = fall_q.pop_front();
                    check("ack_fall_latency", cyc, fc);
                    check("cs_fall", cs_now, 0);
                end
            end
            ack_prev = bus.cpu_ack;
        end
    end

    function automatic logic [2:0] sel_of(input logic [1:0] a);
        if (a == 2'd0) return 3'b000;
        return 3'(1 << (a - 1));
    endfunction

    task automatic issue(input logic [1:0] a, input logic [7:0] d);
        exp_t e;
        if ($urandom_range(1) == 1) begin
            @(negedge clk);
            bus.cpu_cs_n = 1'b0;
        end
        @(negedge clk);
        bus.cpu_addr = a;
        bus.cpu_data = d;
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b0;
        model_data = d;
        if (a != 2'd0) model_cnt = (model_cnt + 1) % 256;
        e.cs   = sel_of(a);
        e.data = d;
        e.cnt  = 8'(model_cnt);
        e.cyc  = cyc + SS + 2;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        bit got;
        issue(a, d);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) check("ack_timeout", 0, 1);
        repeat (hold) @(negedge clk);
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        bus.cpu_addr = 2'($urandom);
        bus.cpu_data = 8'($urandom);
        if (got) fall_q.push_back(cyc + 1 + SS);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.cpu_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) check("ack_release_timeout", 0, 1);
        repeat ($urandom_range(3)) @(negedge clk);
    endtask

    task automatic glitch();
        @(negedge clk);
        bus.cpu_addr = 2'($urandom);
        bus.cpu_data = 8'($urandom);
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b0;
        @(negedge clk);
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        repeat (SS + 6) @(negedge clk);
        check("glitch_data_in", bus.data_in, model_data);
        check("glitch_wr_cnt", bus.wr_cnt, model_cnt);
    endtask

    task automatic reset_mid_write();
        bit got;
        issue(2'd2, 8'h5A);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (bus.my_wr) begin
                got = 1;
                break;
            end
        end
        if (!got) check("rst_my_wr_timeout", 0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_my_wr", bus.my_wr, 0);
        check("rst_cs", {bus.CS_reg3, bus.CS_reg2, bus.CS_reg1}, 0);
        check("rst_ack", bus.cpu_ack, 0);
        check("rst_wr_cnt", bus.wr_cnt, 0);
        check("rst_data_in", bus.data_in, 0);
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        exp_q.delete();
        fall_q.delete();
        model_cnt  = 0;
        model_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_write(2'd3, 8'hC3, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        model_cnt  = 0;
        model_data = 8'h00;
        pend       = 1'b0;
        ack_prev   = 1'b0;
        rst_n      = 1'b0;
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        bus.cpu_addr = 2'd0;
        bus.cpu_data = 8'h00;
        #3;
        check("reset_my_wr", bus.my_wr, 0);
        check("reset_cs", {bus.CS_reg3, bus.CS_reg2, bus.CS_reg1}, 0);
        check("reset_ack", bus.cpu_ack, 0);
        check("reset_data_in", bus.data_in, 0);
        check("reset_wr_cnt", bus.wr_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_write(2'd1, 8'hA5, 2);
        check("first_wr_cnt", bus.wr_cnt, 1);
        glitch();
        do_write(2'd0, 8'h3C, 1);
        check("unmapped_wr_cnt", bus.wr_cnt, 1);
        check("unmapped_data_in", bus.data_in, 8'h3C);

        for (int i = 0; i < 256; i++) begin
            do_write(2'(i % 3 + 1), 8'($urandom), $urandom_range(2));
        end
        check("wrap_wr_cnt", bus.wr_cnt, model_cnt);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(4) == 0) glitch();
            do_write(2'($urandom), 8'($urandom), $urandom_range(3));
        end

        reset_mid_write();
        check("post_reset_wr_cnt", bus.wr_cnt, 1);

        repeat (10) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("fall_q_drained", fall_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
